req_gnt_monitor: RTL and testbench

REQ_GNT_MONITOR -- requirements
Module: req_gnt_monitor

---
 rtl/req_gnt_monitor.sv | 149 ++++++++++++++
 tb/tb_req_gnt_monitor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/req_gnt_monitor.sv
// Per-channel req->gnt latency checker with aggregate saturating event counters.
// Optional: define REQ_GNT_MON_EARLY_FAIL_EN to flag grants arriving before MIN_LAT as failures.

module req_gnt_chan #(
  parameter int MIN_LAT = 1,
  parameter int MAX_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic i_req,
  input  logic i_gnt,
  output logic o_trig,
  output logic o_pass,
  output logic o_fail,
  output logic o_pass_pulse,
  output logic o_fail_pulse,
  output logic o_pending
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] MIN_K = 8'(MIN_LAT);
  localparam logic [7:0] MAX_K = 8'(MAX_LAT);

  state_t     r_state;
  logic [7:0] r_k;
  logic [7:0] w_k;

  // w_k is the distance this edge represents once the wait has started
  assign w_k       = r_k + 8'd1;
  assign o_pending = (r_state == S_WAIT);

  always_comb begin
    o_trig = (r_state == S_IDLE) && i_req;
    o_pass = (r_state == S_WAIT) && i_gnt && (w_k >= MIN_K) && (w_k <= MAX_K);
`ifdef REQ_GNT_MON_EARLY_FAIL_EN
    o_fail = (r_state == S_WAIT) && (((w_k == MAX_K) && !i_gnt) || (i_gnt && (w_k < MIN_K)));
`else
    o_fail = (r_state == S_WAIT) && (w_k == MAX_K) && !i_gnt;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      o_pass_pulse <= 1'b0;
      o_fail_pulse <= 1'b0;
    end else if (clear) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      o_pass_pulse <= 1'b0;
      o_fail_pulse <= 1'b0;
    end else begin
      o_pass_pulse <= o_pass;
      o_fail_pulse <= o_fail;
      case (r_state)
        S_IDLE: begin
          if (o_trig) begin
            r_state <= S_WAIT;
            r_k     <= '0;
          end
        end
        S_WAIT: begin
          // req is deliberately not looked at here: no retrigger on the resolving edge
          if (o_pass || o_fail) begin
            r_state <= S_IDLE;
            r_k     <= '0;
          end else begin
            r_k <= w_k;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

module req_gnt_monitor #(
  parameter int NCH     = 4,
  parameter int MIN_LAT = 1,
  parameter int MAX_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [NCH-1:0]   req,
  input  logic [NCH-1:0]   gnt,
  output logic [NCH-1:0]   pass_pulse,
  output logic [NCH-1:0]   fail_pulse,
  output logic [NCH-1:0]   pending,
  output logic [CNT_W-1:0] trig_cnt,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             vacuous
);
  logic [NCH-1:0]   w_trig, w_pass, w_fail;
  logic [CNT_W-1:0] r_trig_cnt, r_pass_cnt, r_fail_cnt;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    req_gnt_chan #(.MIN_LAT(MIN_LAT), .MAX_LAT(MAX_LAT)) u_chan (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .i_req        (req[i]),
      .i_gnt        (gnt[i]),
      .o_trig       (w_trig[i]),
      .o_pass       (w_pass[i]),
      .o_fail       (w_fail[i]),
      .o_pass_pulse (pass_pulse[i]),
      .o_fail_pulse (fail_pulse[i]),
      .o_pending    (pending[i])
    );
  end

  function automatic logic [5:0] popc(input logic [NCH-1:0] v);
    popc = '0;
    for (int i = 0; i < NCH; i++) popc = popc + 6'(v[i]);
  endfunction

  // Sum in a wider domain so a multi-channel burst cannot wrap past the ceiling
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [5:0] b);
    logic [CNT_W+6:0] s;
    s = {7'd0, a} + {{(CNT_W+1){1'b0}}, b};
    sat_add = (s > {7'd0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trig_cnt <= '0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
    end else if (clear) begin
      r_trig_cnt <= '0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
    end else begin
      r_trig_cnt <= sat_add(r_trig_cnt, popc(w_trig));
      r_pass_cnt <= sat_add(r_pass_cnt, popc(w_pass));
      r_fail_cnt <= sat_add(r_fail_cnt, popc(w_fail));
    end
  end

  assign trig_cnt = r_trig_cnt;
  assign pass_cnt = r_pass_cnt;
  assign fail_cnt = r_fail_cnt;
  assign vacuous  = (r_trig_cnt == '0);
endmodule

// File: tb/tb_req_gnt_monitor.sv
// Scoreboard bench: DUT A (NCH=4, 1..2, 16-bit) and DUT B (NCH=4, 2..3, 2-bit counters) share stimulus.
module tb_req_gnt_monitor;
`ifdef REQ_GNT_MON_EARLY_FAIL_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic [3:0] req = '0, gnt = '0;

  logic [3:0]  pass_pulse_a, fail_pulse_a, pending_a, pass_pulse_b, fail_pulse_b, pending_b;
  logic [15:0] trig_cnt_a, pass_cnt_a, fail_cnt_a;
  logic [1:0]  trig_cnt_b, pass_cnt_b, fail_cnt_b;
  logic        vacuous_a, vacuous_b;

  always #5 clk = ~clk;

  req_gnt_monitor #(.NCH(4), .MIN_LAT(1), .MAX_LAT(2), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .clear(clear), .req(req), .gnt(gnt),
    .pass_pulse(pass_pulse_a), .fail_pulse(fail_pulse_a), .pending(pending_a),
    .trig_cnt(trig_cnt_a), .pass_cnt(pass_cnt_a), .fail_cnt(fail_cnt_a), .vacuous(vacuous_a));

  req_gnt_monitor #(.NCH(4), .MIN_LAT(2), .MAX_LAT(3), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .clear(clear), .req(req), .gnt(gnt),
    .pass_pulse(pass_pulse_b), .fail_pulse(fail_pulse_b), .pending(pending_b),
    .trig_cnt(trig_cnt_b), .pass_cnt(pass_cnt_b), .fail_cnt(fail_cnt_b), .vacuous(vacuous_b));

  typedef struct {
    logic [3:0] pp, fp, pend;
    int         tc, pc, fc;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0, n_err = 0;
  int   st[2][4], kk[2][4];
  int   e_tc[2], e_pc[2], e_fc[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin st[d][c] = 0; kk[d][c] = 0; end
      e_tc[d] = 0; e_pc[d] = 0; e_fc[d] = 0;
    end
  endtask

  // Reference behaviour for one rising edge, pushed before the edge happens
  task automatic model_step(input int d, input logic [3:0] r, input logic [3:0] g, input logic c);
    int   mn, mx, cmax, nt, np, nf, kn;
    exp_t e;
    mn = (d == 0) ? 1 : 2;
    mx = (d == 0) ? 2 : 3;
    cmax = (d == 0) ? 65535 : 3;
    e.pp = '0; e.fp = '0; e.pend = '0;
    if (c) begin
      for (int ch = 0; ch < 4; ch++) begin st[d][ch] = 0; kk[d][ch] = 0; end
      e_tc[d] = 0; e_pc[d] = 0; e_fc[d] = 0;
    end else begin
      nt = 0; np = 0; nf = 0;
      for (int ch = 0; ch < 4; ch++) begin
        if (st[d][ch] == 0) begin
          if (r[ch]) begin st[d][ch] = 1; kk[d][ch] = 0; nt++; end
        end else begin
          kn = kk[d][ch] + 1;
          if (g[ch] && kn >= mn && kn <= mx) begin
            st[d][ch] = 0; e.pp[ch] = 1'b1; np++;
          end else if ((EARLY && g[ch] && kn < mn) || kn == mx) begin
            st[d][ch] = 0; e.fp[ch] = 1'b1; nf++;
          end else kk[d][ch] = kn;
        end
      end
      e_tc[d] = (e_tc[d] + nt > cmax) ? cmax : e_tc[d] + nt;
      e_pc[d] = (e_pc[d] + np > cmax) ? cmax : e_pc[d] + np;
      e_fc[d] = (e_fc[d] + nf > cmax) ? cmax : e_fc[d] + nf;
    end
    for (int ch = 0; ch < 4; ch++) e.pend[ch] = (st[d][ch] == 1);
    e.tc = e_tc[d]; e.pc = e_pc[d]; e.fc = e_fc[d];
    sbq.push_back(e);
  endtask

  task automatic cyc(input logic [3:0] r, input logic [3:0] g, input logic c);
    exp_t e;
    @(negedge clk);
    req = r; gnt = g; clear = c;
    model_step(0, r, g, c);
    model_step(1, r, g, c);
    @(posedge clk); #1;
    if (sbq.size() < 2) begin
      chk("sb.underflow", sbq.size(), 2);
    end else begin
      e = sbq.pop_front();
      chk("A.pass_pulse", pass_pulse_a, e.pp);
      chk("A.fail_pulse", fail_pulse_a, e.fp);
      chk("A.pending", pending_a, e.pend);
      chk("A.trig_cnt", trig_cnt_a, e.tc);
      chk("A.pass_cnt", pass_cnt_a, e.pc);
      chk("A.fail_cnt", fail_cnt_a, e.fc);
      chk("A.vacuous", vacuous_a, e.tc == 0);
      e = sbq.pop_front();
      chk("B.pass_pulse", pass_pulse_b, e.pp);
      chk("B.fail_pulse", fail_pulse_b, e.fp);
      chk("B.pending", pending_b, e.pend);
      chk("B.trig_cnt", trig_cnt_b, e.tc);
      chk("B.pass_cnt", pass_cnt_b, e.pc);
      chk("B.fail_cnt", fail_cnt_b, e.fc);
      chk("B.vacuous", vacuous_b, e.tc == 0);
    end
  endtask

  // Assert mid-cycle so the asynchronous path is what clears the outputs
  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b1; req = '0; gnt = '0; clear = 1'b0;
    #1;
    mreset();
    chk("rst.trig_a", trig_cnt_a, 0);
    chk("rst.pass_a", pass_cnt_a, 0);
    chk("rst.fail_a", fail_cnt_a, 0);
    chk("rst.pend_a", pending_a, 0);
    chk("rst.ppulse_a", pass_pulse_a, 0);
    chk("rst.fpulse_a", fail_pulse_a, 0);
    chk("rst.vac_a", vacuous_a, 1);
    chk("rst.trig_b", trig_cnt_b, 0);
    chk("rst.pend_b", pending_b, 0);
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  initial begin
    // idle after reset: nothing triggers
    do_reset();
    repeat (10) cyc(4'h0, 4'h0, 1'b0);
    chk("idle.trig_a", trig_cnt_a, 0);
    chk("idle.vac_a", vacuous_a, 1);

    // trigger on the first edge after reset, grant at k=2
    do_reset();
    cyc(4'h1, 4'h0, 1'b0);
    cyc(4'h0, 4'h0, 1'b0);
    cyc(4'h0, 4'h1, 1'b0);
    chk("pass.pulse_a", pass_pulse_a, 4'h1);
    chk("pass.cnt_a", pass_cnt_a, 1);
    chk("pass.vac_a", vacuous_a, 0);
    cyc(4'h0, 4'h0, 1'b0);
    chk("pass.pulse_gone_a", pass_pulse_a, 4'h0);

    // timeout
    do_reset();
    cyc(4'h1, 4'h0, 1'b0);
    chk("tmo.pend0_a", pending_a, 4'h1);
    cyc(4'h0, 4'h0, 1'b0);
    chk("tmo.pend1_a", pending_a, 4'h1);
    cyc(4'h0, 4'h0, 1'b0);
    chk("tmo.fpulse_a", fail_pulse_a, 4'h1);
    chk("tmo.pend2_a", pending_a, 4'h0);
    chk("tmo.fcnt_a", fail_cnt_a, 1);

    // early grant on B (window 2..3), then grant again at k=3
    do_reset();
    cyc(4'h1, 4'h0, 1'b0);
    cyc(4'h0, 4'h1, 1'b0);
    cyc(4'h0, 4'h0, 1'b0);
    cyc(4'h0, 4'h1, 1'b0);
    cyc(4'h0, 4'h0, 1'b0);
    chk("early.fail_b", fail_cnt_b, EARLY ? 1 : 0);
    chk("early.pass_b", pass_cnt_b, EARLY ? 0 : 1);
    chk("early.pass_a", pass_cnt_a, 1);

    // all channels at once, then saturation of B's 2-bit counters
    do_reset();
    cyc(4'hF, 4'h0, 1'b0);
    chk("all.trig_a", trig_cnt_a, 4);
    chk("all.trig_b", trig_cnt_b, 3);
    cyc(4'h0, 4'h0, 1'b0);
    cyc(4'h0, 4'h0, 1'b0);
    chk("all.fail_a", fail_cnt_a, 4);
    chk("all.fpulse_a", fail_pulse_a, 4'hF);
    cyc(4'h0, 4'h0, 1'b0);
    chk("all.fail_b", fail_cnt_b, 3);
    cyc(4'h1, 4'h0, 1'b0);
    chk("sat.trig_b", trig_cnt_b, 3);
    chk("sat.trig_a", trig_cnt_a, 5);

    // clear on the resolving edge beats the pass and the new req
    do_reset();
    cyc(4'h1, 4'h0, 1'b0);
    cyc(4'h0, 4'h0, 1'b0);
    cyc(4'h1, 4'h1, 1'b1);
    chk("clr.pass_a", pass_cnt_a, 0);
    chk("clr.trig_a", trig_cnt_a, 0);
    chk("clr.pend_a", pending_a, 0);
    chk("clr.ppulse_a", pass_pulse_a, 0);
    cyc(4'h0, 4'h0, 1'b0);

    // reset while waiting at k=1 drops the transaction
    cyc(4'h1, 4'h0, 1'b0);
    cyc(4'h0, 4'h0, 1'b0);
    do_reset();
    repeat (4) cyc(4'h0, 4'h1, 1'b0);
    chk("rstw.pass_a", pass_cnt_a, 0);
    chk("rstw.fail_a", fail_cnt_a, 0);

    // random traffic with occasional clear
    for (int i = 0; i < 400; i++)
      cyc(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ($urandom_range(0, 31) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
